debouncer_multi: RTL and testbench
==================================

DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent debounce channels; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2_000_000: consecutive stable samples required to accept a new level; legal range 2..2^24.
REQ-003 Parameter RESET_LEVEL, default 1'b0: level loaded into every debounced output at reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 noisy  input  CHANNELS  raw bouncing inputs, one bit per channel, asynchronous to clk.
REQ-007 debounced  output  CHANNELS  filtered level per channel, registered.
REQ-008 rise  output  CHANNELS  one-cycle pulse when the matching debounced bit goes 0->1, registered.
REQ-009 fall  output  CHANNELS  one-cycle pulse when the matching debounced bit goes 1->0, registered.

Function
REQ-010 Each channel has its own 4-state FSM (STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW) and its own counter of width clog2(DEBOUNCE_CYCLES); channels do not interact.
REQ-011 STABLE_LOW: sampled input 1 -> WAIT_HIGH with counter cleared to 0; otherwise hold.
REQ-012 WAIT_HIGH: sampled input 0 -> STABLE_LOW, no output change, no pulse; input 1 with counter == DEBOUNCE_CYCLES-2 -> STABLE_HIGH; otherwise counter increments.
REQ-013 STABLE_HIGH and WAIT_LOW mirror REQ-011/REQ-012 with levels inverted.
REQ-014 debounced is 1 in STABLE_HIGH and WAIT_LOW, and 0 in STABLE_LOW and WAIT_HIGH.
REQ-015 Latency: debounced changes on the clock edge that registers the DEBOUNCE_CYCLES-th consecutive sample of the new level.
REQ-016 rise/fall assert on that same edge and clear on the next edge; rise and fall are never asserted together on one channel.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES samples produces no change on debounced, rise or fall.
REQ-018 The counter never exceeds DEBOUNCE_CYCLES-2 and never wraps.
REQ-019 Multiple channels changing on the same edge each produce their own pulses on the same edge.

Reset
REQ-020 While reset_n is low, debounced = {CHANNELS{RESET_LEVEL}}, rise = 0, fall = 0, counters = 0, and each FSM is STABLE_HIGH if RESET_LEVEL = 1, otherwise STABLE_LOW.
REQ-021 Reset asserted mid-WAIT aborts the pending transition; no pulse is emitted during or on release of reset.
REQ-022 Synchronizer flops, when present, reset to RESET_LEVEL.

Configuration
REQ-023 With macro DEBOUNCER_MULTI_SYNC_EN defined, each noisy bit passes through a 2-flop synchronizer before the FSM, and the REQ-015 latency grows by exactly 2 cycles.
REQ-024 Without DEBOUNCER_MULTI_SYNC_EN, the FSM samples noisy directly; the system integrator guarantees that noisy is already synchronous to clk.

Verification (CHANNELS=4, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, macro undefined unless stated)
REQ-025 Reset release with noisy=4'b0000 -> debounced=0, rise=0, fall=0 for 20 cycles.
REQ-026 noisy[0] held 1 from edge 0 -> debounced[0]=1 and rise[0]=1 after edge 3; rise[0]=0 after edge 4.
REQ-027 noisy[1] pulsed high for 3 edges, then low -> debounced[1], rise[1] and fall[1] stay 0 throughout.
REQ-028 noisy=4'b1111 held for 4 edges, then 4'b0000 held for 4 edges -> all rise bits pulse together, then all fall bits pulse together 4 edges later.
REQ-029 noisy[2] high for 2 edges, then reset_n pulsed low, then noisy[2] held high -> no pulse before or during reset; rise[2] pulses on the 4th edge after reset release.
REQ-030 DEBOUNCER_MULTI_SYNC_EN defined, noisy[3] held 1 from edge 0 -> debounced[3]=1 and rise[3]=1 after edge 5.

Source files
------------

// File: rtl/debouncer_multi.sv
// debouncer_multi
//   Purpose : per-channel switch/contact debouncer. Each channel runs its own
//             4-state FSM and counter; a new level is accepted only after
//             DEBOUNCE_CYCLES consecutive samples of that level.
//   Latency : debounced/rise/fall change on the edge that registers the
//             DEBOUNCE_CYCLES-th consecutive sample of the new level
//             (+2 cycles when DEBOUNCER_MULTI_SYNC_EN is defined).
//   Backpressure: none; every cycle is sampled, outputs are level/pulse.
//
// Ports
//   clk        : single clock, rising edge
//   reset_n    : asynchronous active-low reset
//   noisy      : raw inputs, one bit per channel
//   debounced  : filtered level per channel (registered)
//   rise/fall  : one-cycle pulses on debounced 0->1 / 1->0 (registered)
//
// Configuration macro
//   DEBOUNCER_MULTI_SYNC_EN : when defined, each noisy bit passes through a
//   2-flop synchronizer (reset to RESET_LEVEL) before the FSM. When undefined,
//   noisy must already be synchronous to clk.

module debouncer_multi #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // The counter counts samples already seen in a WAIT state beyond the
  // first one, so it only ever needs to reach DEBOUNCE_CYCLES-2.
  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_e;

  localparam state_e RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  // Level actually seen by the FSMs.
  logic [CHANNELS-1:0] sample;

`ifdef DEBOUNCER_MULTI_SYNC_EN
  logic [CHANNELS-1:0] sync_meta_q;
  logic [CHANNELS-1:0] sync_q;

  // Synchronizer flops reset to the idle level so reset release never looks
  // like an input edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_q <= {CHANNELS{RESET_LEVEL}};
      sync_q      <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync_meta_q <= noisy;
      sync_q      <= sync_meta_q;
    end
  end

  assign sample = sync_q;
`else
  assign sample = noisy;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             deb_q,   deb_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= RESET_STATE;
        cnt_q   <= '0;
        deb_q   <= RESET_LEVEL;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        deb_q   <= deb_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      case (state_q)
        STABLE_LOW: begin
          if (sample[g]) begin
            state_d = WAIT_HIGH;
            cnt_d   = '0;
          end
        end

        WAIT_HIGH: begin
          if (!sample[g]) begin
            // Bounce back to the old level: abandon silently.
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        STABLE_HIGH: begin
          if (!sample[g]) begin
            state_d = WAIT_LOW;
            cnt_d   = '0;
          end
        end

        WAIT_LOW: begin
          if (sample[g]) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = RESET_STATE;
          cnt_d   = '0;
        end
      endcase

      // Output level follows the accepted level of the next state, so the
      // registered output changes on the same edge as the state.
      deb_d  = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
      rise_d =  deb_d & ~deb_q;
      fall_d = ~deb_d &  deb_q;
    end

    assign debounced[g] = deb_q;
    assign rise[g]      = rise_q;
    assign fall[g]      = fall_q;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi
//   Purpose : directed stimulus for debouncer_multi (4 channels, 4 cycles),
//             checked against a run-length model and literal expectations.
//   Latency : model assumes acceptance on the DEB-th consecutive sample.
//   Backpressure: n/a.

module tb_debouncer_multi;

  localparam int CH  = 4;
  localparam int DEB = 4;
`ifdef DEBOUNCER_MULTI_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // Edge index (first edge with the new level = edge 0) on which it is accepted.
  localparam int LAT = DEB - 1 + SYNC;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic [CH-1:0] noisy   = '0;
  logic [CH-1:0] debounced;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debouncer_multi #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .noisy    (noisy),
    .debounced(debounced),
    .rise     (rise),
    .fall     (fall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model: a channel flips its accepted level once it has seen DEB
  // consecutive samples differing from it; any agreeing sample resets the run.
  // ---------------------------------------------------------------------
  logic [CH-1:0] m_level, m_rise, m_fall, m_p1, m_p2, m_s;
  int            m_run [CH];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_p1    = '0;
      m_p2    = '0;
      for (int c = 0; c < CH; c++) m_run[c] = 0;
    end else begin
      if (SYNC != 0) begin
        m_s  = m_p2;
        m_p2 = m_p1;
        m_p1 = noisy;
      end else begin
        m_s = noisy;
      end
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        if (m_s[c] != m_level[c]) m_run[c] = m_run[c] + 1;
        else                      m_run[c] = 0;
        if (m_run[c] == DEB) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_rise[c] = 1'b1;
          else            m_fall[c] = 1'b1;
          m_run[c] = 0;
        end
      end
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    check("debounced", 32'(debounced), 32'(m_level));
    check("rise",      32'(rise),      32'(m_rise));
    check("fall",      32'(fall),      32'(m_fall));
    check("rise_and_fall_together", 32'(rise & fall), 32'd0);
  end

  // Mixed multi-channel vectors: value and number of edges it is held.
  logic [CH-1:0] tab_val  [0:9] = '{4'b0101, 4'b1010, 4'b1111, 4'b1110, 4'b0110,
                                    4'b0000, 4'b1001, 4'b1011, 4'b0011, 4'b0000};
  int            tab_hold [0:9] = '{5, 2, 6, 1, 7, 3, 8, 2, 6, 9};

  int            rise_edge, fall_edge;
  logic [CH-1:0] seen;

  initial begin
    // Reset
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_debounced", 32'(debounced), 32'd0);
    check("reset_pulses",    32'(rise | fall), 32'd0);
    reset_n = 1'b1;

    // Idle after reset release: nothing moves for 20 cycles.
    seen = '0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | debounced | rise | fall;
    end
    check("idle_20_cycles", 32'(seen), 32'd0);

    // Channel 0 held high from edge 0.
    noisy = 4'b0001;
    for (int e = 0; e <= LAT + 1; e++) begin
      @(negedge clk);
      if (e == LAT - 1) check("ch0_before_accept", 32'(debounced[0]), 32'd0);
      if (e == LAT) begin
        check("ch0_debounced_at_lat", 32'(debounced[0]), 32'd1);
        check("ch0_rise_at_lat",      32'(rise[0]),      32'd1);
      end
      if (e == LAT + 1) begin
        check("ch0_rise_cleared",  32'(rise[0]),      32'd0);
        check("ch0_level_held",    32'(debounced[0]), 32'd1);
      end
    end
    noisy = 4'b0000;
    repeat (DEB + SYNC + 2) @(negedge clk);
    check("ch0_back_low", 32'(debounced[0]), 32'd0);

    // Channel 1 glitch of DEB-1 samples: no effect.
    seen  = '0;
    noisy = 4'b0010;
    repeat (DEB - 1) begin
      @(negedge clk);
      seen = seen | debounced | rise | fall;
    end
    noisy = 4'b0000;
    repeat (10) begin
      @(negedge clk);
      seen = seen | debounced | rise | fall;
    end
    check("ch1_glitch_quiet", 32'(seen[1]), 32'd0);

    // All channels together: high for DEB edges, then low for DEB edges.
    rise_edge = -1;
    fall_edge = -1;
    noisy     = 4'b1111;
    for (int e = 0; e < 14; e++) begin
      @(negedge clk);
      if (e == DEB - 1) noisy = 4'b0000;
      if (rise == 4'b1111 && rise_edge < 0) rise_edge = e;
      if (fall == 4'b1111 && fall_edge < 0) fall_edge = e;
    end
    check("all_rise_edge", 32'(rise_edge), 32'(LAT));
    check("all_fall_edge", 32'(fall_edge), 32'(LAT + DEB));

    // Channel 2: pending rise aborted by reset, then re-qualified.
    seen  = '0;
    noisy = 4'b0100;
    repeat (2) begin
      @(negedge clk);
      seen = seen | rise | fall;
    end
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | rise | fall;
    end
    check("no_pulse_around_reset", 32'(seen), 32'd0);
    check("ch2_low_in_reset",      32'(debounced[2]), 32'd0);
    reset_n   = 1'b1;
    rise_edge = -1;
    for (int e = 1; e <= LAT + 3; e++) begin
      @(negedge clk);
      if (rise[2] && rise_edge < 0) rise_edge = e;
    end
    check("ch2_rise_after_reset", 32'(rise_edge), 32'(DEB + SYNC));

    // Mixed vectors, checked by the model only.
    for (int i = 0; i < 10; i++) begin
      noisy = tab_val[i];
      repeat (tab_hold[i]) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("final_all_low", 32'(debounced), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
